// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the pipelined multiplier and the planned adder.
// Holds default field widths, packed-field bit positions and result-class codes.
package fp_pkg;

  localparam int unsigned FP_EXP_W = 8;
  localparam int unsigned FP_MAN_W = 18;
  localparam int unsigned FP_BIAS  = 2 ** (FP_EXP_W - 1) - 1;
  localparam int unsigned FP_TAG_W = 4;
  localparam int unsigned FP_W     = 1 + FP_EXP_W + FP_MAN_W;

  // Bit positions inside a packed {sign, exp, man} word
  localparam int unsigned FP_SIGN_IDX = FP_W - 1;
  localparam int unsigned FP_EXP_MSB  = FP_W - 2;
  localparam int unsigned FP_EXP_LSB  = FP_MAN_W;
  localparam int unsigned FP_MAN_MSB  = FP_MAN_W - 1;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_OVF    = 2'd2,
    CLS_UF     = 2'd3
  } fp_cls_e;

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// master drives operands and result ready; slave is the multiplier.
interface fp_mul_pipe_if #(
  parameter int unsigned EXP_W = fp_pkg::FP_EXP_W,
  parameter int unsigned MAN_W = fp_pkg::FP_MAN_W,
  parameter int unsigned TAG_W = fp_pkg::FP_TAG_W
) ();

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_res;
  logic [TAG_W-1:0] out_tag;
  logic             out_ovf;
  logic             out_uf;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag, out_ovf, out_uf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag, out_ovf, out_uf
  );

endinterface

// File: rtl/fp_round_norm.sv
// Combinational normalise, round-to-nearest-even and exception packing of a raw
// significand product; shared between the multiplier and the future adder.
module fp_round_norm
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W
) (
  input  logic                        sign,
  input  logic                        zero,
  input  logic signed [EXP_W+1:0]     exp_in,
  input  logic        [2*MAN_W+1:0]   prod,
  output logic        [EXP_W+MAN_W:0] res,
  output fp_cls_e                     cls
);

  localparam int unsigned P_W   = 2 * MAN_W + 2;
  localparam int unsigned EW    = EXP_W + 3;
  localparam int signed   E_MAX = (1 << EXP_W) - 1;

  logic [MAN_W-1:0]     man_t;
  logic [MAN_W:0]       man_r;
  logic                 guard;
  logic                 sticky;
  logic signed [EW-1:0] e_n;
  logic signed [EW-1:0] e_r;

  always_comb begin
    man_t  = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    e_n    = EW'(exp_in);
    // Product lies in [1,4): a set MSB means the binary point moves one place
    if (prod[P_W-1]) begin
      man_t  = prod[P_W-2 -: MAN_W];
      guard  = prod[MAN_W];
      sticky = |prod[MAN_W-1:0];
      e_n    = EW'(exp_in) + EW'(1);
    end else begin
      man_t  = prod[P_W-3 -: MAN_W];
      guard  = prod[MAN_W-1];
      sticky = |prod[MAN_W-2:0];
    end
    man_r = {1'b0, man_t} + (MAN_W+1)'(guard & (sticky | man_t[0]));
    e_r   = man_r[MAN_W] ? (e_n + EW'(1)) : e_n;

    res = {sign, e_r[EXP_W-1:0], man_r[MAN_W-1:0]};
    cls = CLS_NORMAL;
    if (zero) begin
      res = {sign, (EXP_W+MAN_W)'(0)};
      cls = CLS_ZERO;
    end else if (e_r > EW'(E_MAX)) begin
      res = {sign, {(EXP_W+MAN_W){1'b1}}};
      cls = CLS_OVF;
    end else if (e_r <= EW'(0)) begin
      res = {sign, (EXP_W+MAN_W)'(0)};
      cls = CLS_UF;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready backpressure,
// RNE rounding, overflow saturation, underflow flush and a sideband tag.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W,
  parameter int unsigned BIAS  = 2 ** (EXP_W - 1) - 1,
  parameter int unsigned TAG_W = FP_TAG_W
) (
  input  logic        clk,
  input  logic        reset_n,
  fp_mul_pipe_if.slave bus
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned P_W   = 2 * MAN_W + 2;
  localparam int unsigned E_W   = EXP_W + 2;

  logic                  en;
  logic                  v1, v2, v3;
  logic [EXP_W-1:0]      ea, eb;

  logic                  s1_sign, s1_zero;
  logic signed [E_W-1:0] s1_e;
  logic [SIG_W-1:0]      s1_sa, s1_sb;
  logic [TAG_W-1:0]      s1_tag;

  logic                  s2_sign, s2_zero;
  logic signed [E_W-1:0] s2_e;
  logic [P_W-1:0]        s2_p;
  logic [TAG_W-1:0]      s2_tag;

  logic [W-1:0]          rn_res;
  fp_cls_e               rn_cls;
  logic [W-1:0]          res_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  ovf_q, uf_q;

  // The whole pipe advances together unless a finished result is blocked
  assign en           = !v3 || bus.out_ready;
  assign bus.in_ready = en;
  assign ea           = bus.in_a[W-2 -: EXP_W];
  assign eb           = bus.in_b[W-2 -: EXP_W];

  // Stage 1: unpack, sign, zero detect, biased exponent sum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_e    <= '0;
      s1_sa   <= '0;
      s1_sb   <= '0;
      s1_tag  <= '0;
    end else if (en) begin
      v1      <= bus.in_valid;
      s1_sign <= bus.in_a[W-1] ^ bus.in_b[W-1];
      s1_zero <= (ea == '0) || (eb == '0);
      s1_e    <= signed'(E_W'(ea) + E_W'(eb) - E_W'(BIAS));
      s1_sa   <= {1'b1, bus.in_a[MAN_W-1:0]};
      s1_sb   <= {1'b1, bus.in_b[MAN_W-1:0]};
      s1_tag  <= bus.in_tag;
    end
  end

  // Stage 2: significand product
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_zero <= 1'b0;
      s2_e    <= '0;
      s2_p    <= '0;
      s2_tag  <= '0;
    end else if (en) begin
      v2      <= v1;
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_e    <= s1_e;
      s2_p    <= P_W'(s1_sa) * P_W'(s1_sb);
      s2_tag  <= s1_tag;
    end
  end

  fp_round_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_norm (
    .sign   (s2_sign),
    .zero   (s2_zero),
    .exp_in (s2_e),
    .prod   (s2_p),
    .res    (rn_res),
    .cls    (rn_cls)
  );

  // Stage 3: registered result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v3    <= 1'b0;
      res_q <= '0;
      tag_q <= '0;
      ovf_q <= 1'b0;
      uf_q  <= 1'b0;
    end else if (en) begin
      v3    <= v2;
      res_q <= rn_res;
      tag_q <= s2_tag;
      ovf_q <= (rn_cls == CLS_OVF);
      uf_q  <= (rn_cls == CLS_UF);
    end
  end

  assign bus.out_valid = v3;
  assign bus.out_res   = res_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_uf    = uf_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed corner cases plus randomized
// streams scored against an integer-arithmetic RNE reference model.
module tb_fp_mul_pipe;
  import fp_pkg::*;

  localparam int unsigned EW = FP_EXP_W;
  localparam int unsigned MW = FP_MAN_W;
  localparam int unsigned W  = FP_W;
  localparam int unsigned TW = FP_TAG_W;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          ovf;
    logic          uf;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(EW), .MAN_W(MW), .TAG_W(TW)) bus ();

  fp_mul_pipe #(.EXP_W(EW), .MAN_W(MW), .TAG_W(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Exact product of the real significands, rounded to nearest-even by integer division
  function automatic exp_t ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [TW-1:0] tag);
    exp_t r;
    longint unsigned sa, sb, p, qv, rem, half;
    int ea, eb, e, shift;
    logic s;
    s     = a[FP_SIGN_IDX] ^ b[FP_SIGN_IDX];
    ea    = int'(a[FP_EXP_MSB:FP_EXP_LSB]);
    eb    = int'(b[FP_EXP_MSB:FP_EXP_LSB]);
    r.tag = tag;
    r.ovf = 1'b0;
    r.uf  = 1'b0;
    r.res = {s, (W-1)'(0)};
    if (ea == 0 || eb == 0) return r;
    sa    = (64'(1) << MW) | 64'(a[FP_MAN_MSB:0]);
    sb    = (64'(1) << MW) | 64'(b[FP_MAN_MSB:0]);
    p     = sa * sb;
    shift = (p >= (64'(1) << (2*MW+1))) ? MW + 1 : MW;
    e     = ea + eb - int'(FP_BIAS) + (shift - MW);
    qv    = p >> shift;
    rem   = p - (qv << shift);
    half  = 64'(1) << (shift - 1);
    if (rem > half || (rem == half && qv[0])) qv = qv + 1;
    if (qv == (64'(1) << (MW + 1))) begin
      qv = qv >> 1;
      e  = e + 1;
    end
    if (e > (1 << EW) - 1) begin
      r.res = {s, {(W-1){1'b1}}};
      r.ovf = 1'b1;
    end else if (e <= 0) begin
      r.uf = 1'b1;
    end else begin
      r.res = {s, EW'(e), MW'(qv)};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_normal();
    return {1'($urandom), EW'($urandom_range(180, 70)), MW'($urandom)};
  endfunction

  // Presents one operation into an empty pipe and waits for its result
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                       output exp_t got, output int lat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = {bus.out_res, bus.out_tag, bus.out_ovf, bus.out_uf};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_res !== '0) begin bad++; $display("FAIL rst_res: got %h want 0", bus.out_res); end
    total++; if (bus.out_tag !== '0) begin bad++; $display("FAIL rst_tag: got %h want 0", bus.out_tag); end
    total++; if ({bus.out_ovf, bus.out_uf} !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b want 00", {bus.out_ovf, bus.out_uf}); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] ta [3] = '{27'h1FC0000, 27'h1FE0000, 27'h2020000};
    logic [W-1:0] tb [3] = '{27'h2000000, 27'h1FE0000, 27'h5FC0000};
    logic [W-1:0] tr [3] = '{27'h2000000, 27'h2008000, 27'h6020000};
    logic [TW-1:0] tt [3] = '{4'd5, 4'd9, 4'd14};
    exp_t got;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], tt[i], got, lat);
      total++; if (lat != 3) begin bad++; $display("FAIL basic_lat[%0d]: got %0d want 3", i, lat); end
      total++; if (got.res !== tr[i]) begin bad++; $display("FAIL basic_res[%0d]: got %h want %h", i, got.res, tr[i]); end
      total++; if (got.tag !== tt[i] || got.ovf !== 1'b0 || got.uf !== 1'b0) begin
        bad++; $display("FAIL basic_side[%0d]: got tag %h ovf %b uf %b want tag %h 0 0", i, got.tag, got.ovf, got.uf, tt[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [W-1:0] ta [2] = '{27'h1FC0001, 27'h1FC0001};
    logic [W-1:0] tb [2] = '{27'h1FC0001, 27'h1FE0000};
    logic [W-1:0] tr [2] = '{27'h1FC0002, 27'h1FE0002};
    exp_t got;
    int lat;
    for (int i = 0; i < 2; i++) begin
      do_op(ta[i], tb[i], TW'(i + 1), got, lat);
      total++; if (got.res !== tr[i] || lat != 3) begin
        bad++; $display("FAIL round[%0d]: got %h lat %0d want %h lat 3", i, got.res, lat, tr[i]);
      end
    end
  endtask

  task automatic test_exceptions();
    logic [W-1:0] ta [3] = '{27'h3FC0000, 27'h0040000, 27'h4000000};
    logic [W-1:0] tb [3] = '{27'h2400000, 27'h0040000, 27'h2000000};
    logic [W-1:0] tr [3] = '{27'h3FFFFFF, 27'h0000000, 27'h4000000};
    logic [1:0]   tf [3] = '{2'b10, 2'b01, 2'b00};
    exp_t got;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], TW'(i + 7), got, lat);
      total++; if (got.res !== tr[i]) begin bad++; $display("FAIL exc_res[%0d]: got %h want %h", i, got.res, tr[i]); end
      total++; if ({got.ovf, got.uf} !== tf[i]) begin bad++; $display("FAIL exc_flags[%0d]: got %b want %b", i, {got.ovf, got.uf}, tf[i]); end
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 30;
    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    int   sent = 0;
    int   rcvd = 0;
    logic held = 1'b0;
    exp_t hv, got, e;
    for (int i = 0; i < N; i++) begin
      a[i] = W'($urandom);
      b[i] = W'($urandom);
    end
    // Offer back-to-back ops while downstream is blocked
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = (sent < 6);
      bus.in_a      = a[sent];
      bus.in_b      = b[sent];
      bus.in_tag    = TW'(sent);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_mul(a[sent], b[sent], TW'(sent)));
        sent++;
      end
    end
    total++; if (sent != 3) begin bad++; $display("FAIL bp_fill: got %0d accepted want 3", sent); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", bus.out_valid); end
    // Drain with random ready/valid, scoreboarding every result
    for (int c = 0; c < 600 && rcvd < N; c++) begin
      @(negedge clk);
      got = {bus.out_res, bus.out_tag, bus.out_ovf, bus.out_uf};
      if (held) begin
        total++; if (bus.out_valid !== 1'b1 || got !== hv) begin
          bad++; $display("FAIL bp_stable: got v%b %h want v1 %h", bus.out_valid, got, hv);
        end
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
      if (sent < N) begin
        bus.in_a   = a[sent];
        bus.in_b   = b[sent];
        bus.in_tag = TW'(sent);
      end
      #1;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL bp_extra: got %h want no result", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin bad++; $display("FAIL bp_res[%0d]: got %h want %h", rcvd, got, e); end
        end
        rcvd++;
      end
      held = bus.out_valid && !bus.out_ready;
      hv   = got;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_mul(a[sent], b[sent], TW'(sent)));
        sent++;
      end
    end
    total++; if (rcvd != N || q.size() != 0) begin
      bad++; $display("FAIL bp_count: got %0d results %0d pending want %0d 0", rcvd, q.size(), N);
    end
    bus.in_valid = 1'b0;
    q.delete();
  endtask

  task automatic test_reset_midflight();
    exp_t got, e;
    int   lat;
    int   stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = (i < 3);
      bus.in_a      = rand_normal();
      bus.in_b      = rand_normal();
      bus.in_tag    = TW'(i + 10);
    end
    #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_full: got %b want 1", bus.out_valid); end
    reset_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_res !== '0) begin
      bad++; $display("FAIL mid_rst: got v%b %h want v0 0", bus.out_valid, bus.out_res);
    end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL mid_stale: got %0d results want 0", stale); end
    e = ref_mul(27'h2020000, 27'h1FE0000, 4'd3);
    do_op(27'h2020000, 27'h1FE0000, 4'd3, got, lat);
    total++; if (got !== e || lat != 3) begin
      bad++; $display("FAIL mid_after: got %h lat %0d want %h lat 3", got, lat, e);
    end
  endtask

  task automatic test_throughput();
    localparam int N = 100;
    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    int   sent = 0;
    int   rcvd = 0;
    int   stalls = 0;
    int   first = -1;
    int   last = -1;
    exp_t got, e;
    for (int i = 0; i < N; i++) begin
      a[i] = rand_normal();
      b[i] = rand_normal();
    end
    for (int c = 0; c < 400 && rcvd < N; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (sent < N);
      if (sent < N) begin
        bus.in_a   = a[sent];
        bus.in_b   = b[sent];
        bus.in_tag = TW'(sent);
      end
      #1;
      if (bus.in_valid && !bus.in_ready) stalls++;
      if (bus.out_valid) begin
        got = {bus.out_res, bus.out_tag, bus.out_ovf, bus.out_uf};
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL tp_extra: got %h want no result", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin bad++; $display("FAIL tp_res[%0d]: got %h want %h", rcvd, got, e); end
        end
        if (first < 0) first = c;
        last = c;
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_mul(a[sent], b[sent], TW'(sent)));
        sent++;
      end
    end
    total++; if (stalls != 0) begin bad++; $display("FAIL tp_stalls: got %0d want 0", stalls); end
    total++; if (rcvd != N || last - first != N - 1) begin
      bad++; $display("FAIL tp_rate: got %0d results over %0d cycles want %0d over %0d", rcvd, last - first + 1, N, N);
    end
    bus.in_valid = 1'b0;
    q.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_exceptions();
    test_backpressure();
    test_reset_midflight();
    test_throughput();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, 3-stage pipelined floating-point multiplier for the n-body force datapath; successor to the combinational 27-bit multiplier.
- Adds a valid/ready handshake with backpressure, round-to-nearest-even, overflow saturation, underflow flush and a sideband tag.
- Sits between the position-delta/distance units and the force accumulator.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 18, stored mantissa width; the hidden bit is implicit.
- BIAS, 2^(EXP_W-1)-1 (127), exponent bias.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- in_a  in  1+EXP_W+MAN_W  operand A, packed as {sign, exp, man}.
- in_b  in  1+EXP_W+MAN_W  operand B, same packing.
- in_tag  in  TAG_W  sideband tag, returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_res  out  1+EXP_W+MAN_W  product, packed.
- out_tag  out  TAG_W  tag of this result.
- out_ovf  out  1  result was saturated.
- out_uf  out  1  result was flushed to zero by underflow.

Behaviour:
- Reset (asynchronous, reset_n=0): stage valids v1..v3 clear to 0, so out_valid=0. out_res, out_tag, out_ovf and out_uf clear to 0. Any in-flight operation is discarded. in_ready reflects the stall rule immediately and is 1 after reset.
- Stall rule: en = !v3 | out_ready; in_ready = en. When en=1 all stages shift: v1<=in_valid, v2<=v1, v3<=v2. When en=0 every pipeline register holds.
- Bubbles are not collapsed. Latency is exactly 3 accepted cycles; a new operation can be accepted every cycle.
- Handshake: an input transfer occurs on in_valid&in_ready; an output transfer occurs on out_valid&out_ready. out_* stay stable while out_valid=1 and out_ready=0.
- Stage 1:
  - unpack; sign = sa^sb.
  - An operand with exp==0 is treated as zero (denormals flush); zero flag = za|zb.
  - Signed exponent e = ea+eb-BIAS, computed at EXP_W+2 bits.
  - Significands formed as {1,man}.
- Stage 2: product P of the two significands, 2*MAN_W+2 bits.
- Stage 3, normalise:
  - If P MSB is set, the mantissa is taken from the bits below the MSB and e+=1.
  - Otherwise the mantissa is taken from the bits below the MSB-1.
- Stage 3, round (RNE):
  - guard = first dropped bit; sticky = OR of the remaining dropped bits.
  - Increment when guard & (sticky | lsb).
  - If the increment carries out of the mantissa, the mantissa becomes 0 and e+=1.
- Stage 3, exceptions:
  - Zero flag set: result {sign,0,0}, ovf=0, uf=0.
  - Else if e > 2^EXP_W-1: result {sign, all-ones exp, all-ones man}, ovf=1. No inf/NaN encodings exist.
  - Else if e <= 0: result {sign,0,0}, uf=1.
  - Otherwise result {sign, e[EXP_W-1:0], man}.
- in_tag travels with its operation unchanged.
- Simultaneous transfer in the same cycle (input accepted while output consumed) is legal and sustains full throughput.

Decomposition:
- Shared package fp_pkg holds:
  - the EXP_W/MAN_W/BIAS defaults and the derived FP_W;
  - packed-field index helpers;
  - result-class codes (normal, zero, ovf, uf) shared with the planned fp_add_pipe.
- One natural sub-module, fp_round_norm: the stage-3 normalise, RNE round and exception pack logic. It is combinational, so it can be reused by the adder.

Test Plan:
(Default format: 1.0=0x1FC0000, 2.0=0x2000000.)
- Basic: 1.0*2.0, tag 5 -> out_res 0x2000000 with tag 5, out_valid exactly 3 cycles after acceptance. Also 1.5 (0x1FE0000)*1.5 -> 0x2008000; 3.0 (0x2020000)*-1.0 (0x5FC0000) -> 0x6020000.
- Rounding:
  - 0x1FC0001*0x1FC0001 (sticky only, guard 0) -> 0x1FC0002, truncated.
  - 0x1FC0001*0x1FE0000 (guard=1, sticky=0, lsb=1; RNE tie) -> 0x1FE0002.
- Exceptions:
  - 0x3FC0000*0x2400000 -> 0x3FFFFFF with ovf=1.
  - 0x0040000*0x0040000 -> 0x0000000 with uf=1.
  - 0x4000000*0x2000000 (negative zero times 2.0) -> 0x4000000 with no flags.
- Backpressure: stream 6 back-to-back ops with out_ready=0 -> in_ready drops once v3 is set; results then drain in order with correct tags and none lost or duplicated. Toggle out_ready randomly with a scoreboard.
- Reset mid-flight: assert reset_n=0 with 3 ops in flight -> out_valid=0 immediately, no stale result after release; a subsequent op completes normally.
- Throughput: out_ready=1, 100 random normal operands -> one result per cycle, bit-exact against a reference model using RNE.
